// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and flag payload for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational logic/add/sub/SLT unit with status flags; unknown ops flag illegal.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_c,
  output alu_flags_t       flags_c
);

  localparam int unsigned SW = WIDTH + 1;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // SLT shares the subtractor so its sign test survives overflow.
  assign sub   = (op_i == OP_SUB) || (op_i == OP_SLT);
  assign b_eff = sub ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_eff} + SW'(sub);
  assign ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    result_c = '0;
    flags_c  = '0;
    case (op_i)
      OP_AND: result_c = a_i & b_i;
      OP_OR:  result_c = a_i | b_i;
      OP_NOR: result_c = ~(a_i | b_i);
      OP_ADD, OP_SUB: begin
        result_c         = sum[WIDTH-1:0];
        flags_c.carry    = sum[WIDTH];
        flags_c.overflow = ovf;
      end
      OP_SLT: result_c = WIDTH'(sum[WIDTH-1] ^ ovf);
      default: flags_c.illegal = 1'b1;
    endcase
    flags_c.zero = !flags_c.illegal && (result_c == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready wrapper around alu_core_comb with shift-add multiply.
// Define ALU_DIV_EN to add the unsigned restoring divide (op DIVU).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic [DW-1:0]    prod;
  logic             last_step;

  alu_core_comb #(.WIDTH(WIDTH)) u_core (
    .a_i      (a),
    .b_i      (b),
    .op_i     (op),
    .result_c (core_result),
    .flags_c  (core_flags)
  );

  // One shift-add step; on the final step this is the full product.
  assign prod      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             div_by_zero;

  // Restoring divide: mplier holds dividend bits shifting out and quotient bits shifting in.
  assign rem_sh      = {rem_q, mplier_q[WIDTH-1]};
  assign rem_diff    = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
  assign rem_next    = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  assign quo_next    = {mplier_q[WIDTH-2:0], ~rem_diff[WIDTH]};
  assign div_by_zero = (mcand_q[WIDTH-1:0] == '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_DIV_EN
    rem_d    = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = DW'(a);
            mplier_d = b;
            cnt_d    = '0;
            state_d  = S_MUL;
          end
`ifdef ALU_DIV_EN
          else if (op == OP_DIVU) begin
            rem_d    = '0;
            mcand_d  = DW'(b);
            mplier_d = a;
            cnt_d    = '0;
            state_d  = S_DIV;
          end
`endif
          else begin
            result_d = core_result;
            flags_d  = core_flags;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          result_d       = prod[WIDTH-1:0];
          flags_d        = '0;
          flags_d.carry  = |prod[DW-1:WIDTH];
          flags_d.zero   = (prod[WIDTH-1:0] == '0);
          state_d        = S_DONE;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        rem_d    = rem_next;
        mplier_d = quo_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          flags_d = '0;
          if (div_by_zero) begin
            result_d         = '1;
            flags_d.overflow = 1'b1;
          end else begin
            result_d      = quo_next;
            flags_d.carry = (rem_next != '0);
            flags_d.zero  = (quo_next == '0);
          end
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_DIV_EN
      rem_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= (state_d == S_DONE);
      in_ready_q  <= (state_d == S_IDLE);
`ifdef ALU_DIV_EN
      rem_q       <= rem_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + scoreboard bench for alu_seq (WIDTH=24); DIVU cases follow ALU_DIV_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, overflow, illegal;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    logic         il;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, c, v, il, input int lat);
    exp_t e;
    e.r = r; e.z = z; e.c = c; e.v = v; e.il = il; e.lat = lat;
    return e;
  endfunction

  // Reference model in integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t           e;
    longint         sx, sy, s;
    longint         smax, smin;
    logic [2*W-1:0] p;
    logic [W:0]     u;
    e    = mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    case (o)
      OP_AND: e.r = x & y;
      OP_OR:  e.r = x | y;
      OP_NOR: e.r = ~(x | y);
      OP_ADD: begin
        u = {1'b0, x} + {1'b0, y};
        e.r = u[W-1:0]; e.c = u[W];
        s = sx + sy; e.v = (s > smax) || (s < smin);
      end
      OP_SUB: begin
        e.r = x - y; e.c = (x >= y);
        s = sx - sy; e.v = (s > smax) || (s < smin);
      end
      OP_SLT: e.r = (sx < sy) ? W'(1) : W'(0);
      OP_MUL: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.r = p[W-1:0]; e.c = |p[2*W-1:W]; e.lat = W + 1;
      end
      default: e.il = 1'b1;
    endcase
    e.z = !e.il && (e.r == '0);
    return e;
  endfunction

  // Called at a negedge; leaves at the negedge after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("issue_ready", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_has"}, 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({tag, "_result"}, 32'(result), 32'(e.r));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
      chk({tag, "_carry"}, 32'(carry), 32'(e.c));
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.v));
      chk({tag, "_illegal"}, 32'(illegal), 32'(e.il));
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input exp_t e, input int hold);
    issue(o, x, y, e);
    collect(tag, hold);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_flags"}, 32'({zero, carry, overflow, illegal}), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]   ops [7];
    logic [W-1:0] x, y;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL};

    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_cleared("post_reset");

    run("add_ovf", OP_ADD, 24'h7FFFFF, 24'h000001, mk(24'h800000, 1'b0, 1'b0, 1'b1, 1'b0, 1), 0);
    run("sub_eq", OP_SUB, 24'd5, 24'd5, mk(24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1), 0);
    run("slt_ovf", OP_SLT, 24'h800000, 24'h7FFFFF, mk(24'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1), 0);
    run("slt_neg", OP_SLT, 24'h000001, 24'hFFFFFF, mk(24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1), 0);
    run("mul_small", OP_MUL, 24'd3, 24'd7, mk(24'd21, 1'b0, 1'b0, 1'b0, 1'b0, 25), 0);
    run("mul_high", OP_MUL, 24'h001000, 24'h001000, mk(24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 25), 0);
    run("and_bp", OP_AND, 24'hF0F0F0, 24'h0FF0FF, mk(24'h00F0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1), 5);
    run("after_bp", OP_OR, 24'h00000F, 24'h0000F0, mk(24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1), 0);
    run("illegal", 4'b0011, 24'h123456, 24'h654321, mk(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1), 0);

    // out_ready while idle must not produce anything
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("idle_oready_valid", 32'(out_valid), 32'd0);
    chk("idle_oready_ready", 32'(in_ready), 32'd1);

    // Reset 10 cycles into a multiply; no push because it must never complete
    op = OP_MUL; a = 24'h00ABCD; b = 24'h000123; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    op = OP_ADD; a = 24'd1; b = 24'd1; in_valid = 1'b1;
    #1;
    chk_cleared("mid_reset");
    repeat (2) @(negedge clk);
    chk_cleared("mid_reset_hold");
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_late_valid", 32'(out_valid), 32'd0);
    run("add_after_rst", OP_ADD, 24'd2, 24'd2, mk(24'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1), 0);

`ifdef ALU_DIV_EN
    run("divu", OP_DIVU, 24'd100, 24'd7, mk(24'd14, 1'b0, 1'b1, 1'b0, 1'b0, 25), 0);
    run("divu_zero", OP_DIVU, 24'd55, 24'd0, mk(24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 25), 0);
`else
    run("divu_illegal", OP_DIVU, 24'd100, 24'd7, mk(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1), 0);
`endif

    for (int i = 0; i < 14; i++) begin
      x = W'($urandom());
      y = (i % 5 == 0) ? x : W'($urandom());
      run("rnd", ops[i % 7], x, y, model(ops[i % 7], x, y), 0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU for the 24-bit CPU datapath, successor to the per-bit ALU slice.
- Same AND/OR/ADD/SUB/SLT/NOR operation set and encoding, plus status flags and a multi-cycle shift-add multiply.
- Connects to issue logic through valid/ready handshakes on both input and output, and holds its result under backpressure.

Parameters:
- WIDTH, 24: operand and result width; legal range 8..32.
- CNT_W, 5: multiply cycle-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  operation code.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result equals 0.
- carry  output  1  add/sub carry-out, or multiply high-half nonzero.
- overflow  output  1  signed overflow (add/sub only).
- illegal  output  1  op is unsupported.

Behaviour:
- Single clock, clk. Reset is asynchronous, active-low, on rst_n.
- Op encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A+~B+1); 0111 SLT (signed); 1100 NOR; 1000 MUL (low WIDTH bits, unsigned).
  - All other codes are illegal.
- Reset: state IDLE; result, zero, carry, overflow, illegal, out_valid and the counter all 0. in_ready=1 while in IDLE; inputs are ignored while rst_n is low.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Single-cycle or illegal op: register outputs and go to DONE.
    - MUL: latch a and b, clear the accumulator, counter=0, go to MUL.
  - MUL: in_ready=0. Each cycle, if multiplier bit0=1, add the multiplicand; shift the multiplicand left and the multiplier right; counter+1.
    - When counter==WIDTH-1, write result and flags and go to DONE.
    - The accumulator is 2*WIDTH bits wide.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE with out_valid=0.
    - No accept in the same cycle (no bypass), so throughput is at most 1 op per 2 cycles.
- Latency:
  - Single-cycle ops: out_valid rises on the cycle after accept.
  - MUL: out_valid rises WIDTH+1 cycles after accept.
- Flags:
  - zero = (result==0) for every legal op.
  - carry: carry-out of the add/sub; for SUB, carry=1 means no borrow. For MUL, carry=1 if product[2W-1:W]!=0. 0 for logic ops and SLT.
  - overflow: (sign a' == sign b') && (sign sum != sign a'), where b' is the inverted B for SUB. 0 for all other ops.
  - SLT: result = {0..., N^V}, computed from the subtract, so it is correct when the subtract overflows.
  - Illegal op: result=0, zero=0, carry=0, overflow=0, illegal=1. It completes as a single-cycle op.
- Backpressure: result and flags stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: the operation is abandoned; the FSM returns to IDLE and no out_valid is produced.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - Op 1001 is DIVU, an unsigned restoring divide taking WIDTH cycles in state DIV, with the same latency as MUL.
  - result = quotient.
  - carry = 1 if the remainder is nonzero.
  - Divide by zero: result all-ones, overflow=1.
- Undefined: 1001 is illegal; the DIV state and remainder register are absent.

Decomposition:
- Shared package/header alu_pkg holds:
  - OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, OP_DIVU localparams;
  - the state encodings S_IDLE, S_MUL, S_DIV, S_DONE.
- One sub-module: alu_core_comb, a combinational WIDTH-bit logic/add/sub/SLT unit with its flags. alu_seq wraps it with the FSM, the multiply datapath and output registers.

Test Plan:
- ADD a=24'h7FFFFF, b=1 -> result 24'h800000, overflow=1, carry=0, zero=0, out_valid 1 cycle after accept.
- SUB a=5, b=5 -> result 0, zero=1, carry=1, overflow=0. SLT a=24'h800000, b=24'h7FFFFF -> result 1. SLT a=1, b=24'hFFFFFF -> result 0.
- MUL a=3, b=7 -> result 21, carry=0, out_valid exactly 25 cycles after accept. MUL a=b=24'h001000 -> result 0, carry=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles after AND -> result and flags stable, in_ready=0. Then out_ready=1 -> IDLE, and the next op is accepted the following cycle.
- rst_n pulsed low 10 cycles into a MUL -> out_valid=0, all outputs 0, in_ready=1. A following ADD 2+2 returns 4.
- op=4'b0011 -> illegal=1, result=0. With ALU_DIV_EN: DIVU 100/7 -> 14, carry=1; DIVU x/0 -> 24'hFFFFFF, overflow=1.
